// File: rtl/vx_wb_arbiter_if.sv
// Commit-stream bundle between the execute units (sources) and the writeback arbiter.
// The arbiter is the slave; the out_* side is the ack-free writeback stream it produces.
interface vx_wb_arbiter_if #(
  parameter int NUM_INPUTS = 4,
  parameter int DATAW      = 64
);
  localparam int SRC_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  logic [NUM_INPUTS-1:0]       in_valid;
  logic [NUM_INPUTS*DATAW-1:0] in_data;
  logic [NUM_INPUTS-1:0]       in_sop;
  logic [NUM_INPUTS-1:0]       in_eop;
  logic [NUM_INPUTS-1:0]       in_ready;
  logic                        out_valid;
  logic [DATAW-1:0]            out_data;
  logic                        out_sop;
  logic                        out_eop;
  logic [SRC_W-1:0]            out_src;

  modport master (
    output in_valid, in_data, in_sop, in_eop,
    input  in_ready, out_valid, out_data, out_sop, out_eop, out_src
  );

  modport slave (
    input  in_valid, in_data, in_sop, in_eop,
    output in_ready, out_valid, out_data, out_sop, out_eop, out_src
  );
endinterface

// File: rtl/vx_wb_arbiter.sv
// Packet-aware round-robin merge of execute-unit commit streams into one registered,
// ack-free writeback stream, with a saturating conflict counter.
//
//   state    | meaning
//   UNLOCKED | between packets; round-robin scan from rr_ptr picks the grant
//   LOCKED   | mid-packet; only lock_idx may be granted, everyone else stalls
module vx_wb_arbiter #(
  parameter int NUM_INPUTS = 4,
  parameter int DATAW      = 64,
  parameter int PERF_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  vx_wb_arbiter_if.slave    bus,
  output logic [PERF_W-1:0] perf_conflicts
);
  localparam int SRC_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [SRC_W-1:0]      lock_idx, lock_nxt;
  logic [SRC_W-1:0]      rr_ptr, rr_nxt;
  logic [SRC_W-1:0]      grant_idx, cand;
  logic                  grant_vld;
  logic [NUM_INPUTS-1:0] grant_oh;
  logic                  conflict;

  logic                  out_valid_q;
  logic [DATAW-1:0]      out_data_q;
  logic                  out_sop_q;
  logic                  out_eop_q;
  logic [SRC_W-1:0]      out_src_q;

  always_comb begin
    state_nxt = state;
    lock_nxt  = lock_idx;
    rr_nxt    = rr_ptr;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    grant_oh  = '0;

    if (state == LOCKED) begin
      grant_vld = bus.in_valid[lock_idx];
      grant_idx = lock_idx;
    end else begin
      // Scan from the far end so the candidate closest to rr_ptr is written last.
      for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
        cand = SRC_W'((int'(rr_ptr) + k) % NUM_INPUTS);
        if (bus.in_valid[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end

    if (grant_vld) begin
      grant_oh = NUM_INPUTS'(1) << grant_idx;
      if (bus.in_eop[grant_idx]) begin
        state_nxt = UNLOCKED;
        rr_nxt    = SRC_W'((int'(grant_idx) + 1) % NUM_INPUTS);
      end else begin
        state_nxt = LOCKED;
        lock_nxt  = grant_idx;
      end
    end
  end

  assign conflict      = |(bus.in_valid & ~grant_oh);
  assign bus.in_ready  = grant_oh;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sop   = out_sop_q;
  assign bus.out_eop   = out_eop_q;
  assign bus.out_src   = out_src_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= UNLOCKED;
      lock_idx       <= '0;
      rr_ptr         <= '0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_sop_q      <= 1'b0;
      out_eop_q      <= 1'b0;
      out_src_q      <= '0;
      perf_conflicts <= '0;
    end else begin
      state       <= state_nxt;
      lock_idx    <= lock_nxt;
      rr_ptr      <= rr_nxt;
      out_valid_q <= grant_vld;
      // Payload holds its last value across bubbles.
      if (grant_vld) begin
        out_data_q <= bus.in_data[grant_idx*DATAW +: DATAW];
        out_sop_q  <= bus.in_sop[grant_idx];
        out_eop_q  <= bus.in_eop[grant_idx];
        out_src_q  <= grant_idx;
      end
      if (conflict && !(&perf_conflicts))
        perf_conflicts <= perf_conflicts + 1'b1;
    end
  end
endmodule

// File: tb/tb_vx_wb_arbiter.sv
// Bench for vx_wb_arbiter: directed scenarios plus randomized traffic checked against
// a packet-level round-robin reference model.
module tb_vx_wb_arbiter;
  localparam int N  = 4;
  localparam int DW = 64;
  localparam int PW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [PW-1:0] perf;
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vx_wb_arbiter_if #(.NUM_INPUTS(N), .DATAW(DW)) bus();

  vx_wb_arbiter #(.NUM_INPUTS(N), .DATAW(DW), .PERF_W(PW)) dut (
    .clk(clk), .reset(reset), .bus(bus), .perf_conflicts(perf)
  );

  // reference model state
  int   m_rr, m_owner;
  bit   m_locked;
  logic e_v, e_sop, e_eop;
  logic [DW-1:0] e_data;
  logic [1:0] e_src;
  int   e_perf;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] s, input logic [N-1:0] e,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic [DW-1:0] d2, input logic [DW-1:0] d3);
    bus.in_valid = v;
    bus.in_sop   = s;
    bus.in_eop   = e;
    bus.in_data  = {d3, d2, d1, d0};
  endtask

  task automatic apply_reset();
    drive('0, '0, '0, '0, '0, '0, '0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  function automatic int model_grant(input logic [N-1:0] v);
    if (m_locked) return v[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++)
      if (v[(m_rr + k) % N]) return (m_rr + k) % N;
    return -1;
  endfunction

  task automatic test_reset();
    drive('0, '0, '0, '0, '0, '0, '0);
    reset = 1'b1;
    #3;
    n_cmp++; if ({bus.out_valid, bus.out_sop, bus.out_eop, bus.out_src} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {bus.out_valid, bus.out_sop, bus.out_eop, bus.out_src}); end
    n_cmp++; if (bus.out_data !== 64'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", bus.out_data); end
    n_cmp++; if (perf !== 4'd0) begin n_fail++; $display("FAIL reset_perf: got %0d want 0", perf); end
    n_cmp++; if (bus.in_ready !== 4'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", bus.in_ready); end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_single();
    apply_reset();
    drive(4'b0100, 4'b0100, 4'b0100, '0, '0, 64'hA5, '0);
    #1;
    n_cmp++; if (bus.in_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b want 0100", bus.in_ready); end
    tick();
    drive('0, '0, '0, '0, '0, '0, '0);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_src !== 2'd2) begin n_fail++; $display("FAIL single_out: got v=%b src=%0d want v=1 src=2", bus.out_valid, bus.out_src); end
    n_cmp++; if (bus.out_data !== 64'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", bus.out_data); end
    tick();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_after: got v=%b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 64'hA5) begin n_fail++; $display("FAIL single_hold: got %h want a5", bus.out_data); end
    n_cmp++; if (perf !== 4'd0) begin n_fail++; $display("FAIL single_perf: got %0d want 0", perf); end
  endtask

  task automatic test_all_rr();
    apply_reset();
    drive(4'hF, 4'hF, 4'hF, 64'h100, 64'h101, 64'h102, 64'h103);
    for (int c = 0; c < 8; c++) begin
      tick();
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_src !== 2'(c % 4)) begin n_fail++; $display("FAIL rr_src[%0d]: got v=%b src=%0d want v=1 src=%0d", c, bus.out_valid, bus.out_src, c % 4); end
      n_cmp++; if (bus.out_data !== 64'(256 + c % 4)) begin n_fail++; $display("FAIL rr_data[%0d]: got %h want %h", c, bus.out_data, 256 + c % 4); end
    end
    n_cmp++; if (perf !== 4'd8) begin n_fail++; $display("FAIL rr_perf: got %0d want 8", perf); end
    drive('0, '0, '0, '0, '0, '0, '0);
  endtask

  task automatic test_saturate();
    apply_reset();
    drive(4'hF, 4'hF, 4'hF, '0, '0, '0, '0);
    for (int c = 0; c < 20; c++) tick();
    n_cmp++; if (perf !== 4'hF) begin n_fail++; $display("FAIL sat_perf: got %0d want 15", perf); end
    drive(4'b0001, 4'b0001, 4'b0001, '0, '0, '0, '0);
    tick();
    n_cmp++; if (perf !== 4'hF) begin n_fail++; $display("FAIL sat_hold: got %0d want 15", perf); end
    drive('0, '0, '0, '0, '0, '0, '0);
  endtask

  task automatic test_packet();
    logic [3:0] v_t [5] = '{4'b0001, 4'b0011, 4'b0011, 4'b0011, 4'b0001};
    logic       s1_t[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       e1_t[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] r_t [5] = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
    logic [1:0] s_t [5] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      drive(v_t[c], {2'b00, s1_t[c], 1'b1}, {2'b00, e1_t[c], 1'b1}, 64'h0, 64'(16 + c), '0, '0);
      #1;
      n_cmp++; if (bus.in_ready !== r_t[c]) begin n_fail++; $display("FAIL pkt_ready[%0d]: got %b want %b", c, bus.in_ready, r_t[c]); end
      tick();
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_src !== s_t[c]) begin n_fail++; $display("FAIL pkt_src[%0d]: got v=%b src=%0d want v=1 src=%0d", c, bus.out_valid, bus.out_src, s_t[c]); end
      if (s_t[c] == 2'd1) begin
        n_cmp++; if (bus.out_data !== 64'(16 + c) || bus.out_sop !== s1_t[c] || bus.out_eop !== e1_t[c]) begin n_fail++; $display("FAIL pkt_beat[%0d]: got d=%h sop=%b eop=%b want d=%h sop=%b eop=%b", c, bus.out_data, bus.out_sop, bus.out_eop, 16 + c, s1_t[c], e1_t[c]); end
      end
    end
    drive('0, '0, '0, '0, '0, '0, '0);
  endtask

  task automatic test_bubble();
    logic [3:0] v_t [5] = '{4'b0010, 4'b1000, 4'b1010, 4'b1100, 4'b1000};
    logic [3:0] s_t [5] = '{4'b1110, 4'b1100, 4'b1100, 4'b1100, 4'b1100};
    logic [3:0] e_t [5] = '{4'b1100, 4'b1100, 4'b1110, 4'b1100, 4'b1100};
    logic [3:0] r_t [5] = '{4'b0010, 4'b0000, 4'b0010, 4'b0100, 4'b1000};
    logic       ov_t[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [1:0] os_t[5] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd3};
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      drive(v_t[c], s_t[c], e_t[c], '0, '0, '0, '0);
      #1;
      n_cmp++; if (bus.in_ready !== r_t[c]) begin n_fail++; $display("FAIL bub_ready[%0d]: got %b want %b", c, bus.in_ready, r_t[c]); end
      tick();
      n_cmp++; if (bus.out_valid !== ov_t[c] || bus.out_src !== os_t[c]) begin n_fail++; $display("FAIL bub_out[%0d]: got v=%b src=%0d want v=%b src=%0d", c, bus.out_valid, bus.out_src, ov_t[c], os_t[c]); end
    end
    drive('0, '0, '0, '0, '0, '0, '0);
  endtask

  task automatic test_wrap();
    logic [3:0] v_t [3] = '{4'b0100, 4'b1001, 4'b1001};
    logic [3:0] r_t [3] = '{4'b0100, 4'b1000, 4'b0001};
    logic [1:0] os_t[3] = '{2'd2, 2'd3, 2'd0};
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      drive(v_t[c], 4'hF, 4'hF, '0, '0, '0, '0);
      #1;
      n_cmp++; if (bus.in_ready !== r_t[c]) begin n_fail++; $display("FAIL wrap_ready[%0d]: got %b want %b", c, bus.in_ready, r_t[c]); end
      tick();
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_src !== os_t[c]) begin n_fail++; $display("FAIL wrap_out[%0d]: got v=%b src=%0d want v=1 src=%0d", c, bus.out_valid, bus.out_src, os_t[c]); end
    end
    drive('0, '0, '0, '0, '0, '0, '0);
  endtask

  task automatic test_reset_locked();
    apply_reset();
    drive(4'b1100, 4'b1100, 4'b1000, '0, '0, 64'h22, 64'h33);
    tick();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_src !== 2'd2 || perf !== 4'd1) begin n_fail++; $display("FAIL rstlk_pre: got v=%b src=%0d perf=%0d want v=1 src=2 perf=1", bus.out_valid, bus.out_src, perf); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0 || perf !== 4'd0) begin n_fail++; $display("FAIL rstlk_async: got v=%b perf=%0d want v=0 perf=0", bus.out_valid, perf); end
    #1 reset = 1'b0;
    drive(4'hF, 4'hF, 4'hF, '0, '0, '0, '0);
    #1;
    n_cmp++; if (bus.in_ready !== 4'b0001) begin n_fail++; $display("FAIL rstlk_ready: got %b want 0001", bus.in_ready); end
    tick();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_src !== 2'd0) begin n_fail++; $display("FAIL rstlk_first: got v=%b src=%0d want v=1 src=0", bus.out_valid, bus.out_src); end
    drive('0, '0, '0, '0, '0, '0, '0);
  endtask

  task automatic test_random();
    logic [N-1:0]  v, s, e, exp_ready;
    logic [DW-1:0] d [N];
    int g;
    apply_reset();
    m_rr = 0; m_owner = 0; m_locked = 0;
    e_v = 0; e_sop = 0; e_eop = 0; e_data = '0; e_src = '0; e_perf = 0;
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) begin
        v[i] = ($urandom_range(0, 9) < 7);
        s[i] = $urandom_range(0, 1) == 1;
        e[i] = $urandom_range(0, 1) == 1;
        d[i] = {$urandom, $urandom};
      end
      drive(v, s, e, d[0], d[1], d[2], d[3]);
      g = model_grant(v);
      exp_ready = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      #1;
      n_cmp++; if (bus.in_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, bus.in_ready, exp_ready); end
      if (g >= 0) begin
        e_v = 1; e_data = d[g]; e_sop = s[g]; e_eop = e[g]; e_src = 2'(g);
        if (e[g]) begin m_locked = 0; m_rr = (g + 1) % N; end
        else begin m_locked = 1; m_owner = g; end
      end else e_v = 0;
      if ((v & ~exp_ready) != 0 && e_perf < 15) e_perf++;
      tick();
      n_cmp++; if (bus.out_valid !== e_v) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, bus.out_valid, e_v); end
      n_cmp++; if (bus.out_data !== e_data) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h want %h", c, bus.out_data, e_data); end
      n_cmp++; if (bus.out_src !== e_src) begin n_fail++; $display("FAIL rnd_src[%0d]: got %0d want %0d", c, bus.out_src, e_src); end
      n_cmp++; if (bus.out_sop !== e_sop || bus.out_eop !== e_eop) begin n_fail++; $display("FAIL rnd_sopeop[%0d]: got %b%b want %b%b", c, bus.out_sop, bus.out_eop, e_sop, e_eop); end
      n_cmp++; if (perf !== PW'(e_perf)) begin n_fail++; $display("FAIL rnd_perf[%0d]: got %0d want %0d", c, perf, e_perf); end
    end
    drive('0, '0, '0, '0, '0, '0, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_all_rr();
    test_saturate();
    test_packet();
    test_bubble();
    test_wrap();
    test_reset_locked();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
